// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - shared types and constants for the instruction fetch unit
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_WORD   = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES = 32'd4;

    // A redirect target is usable only if word-aligned and inside instruction memory.
    function automatic logic target_ok(input logic [31:0] target, input logic [31:0] limit);
        return (target[1:0] == 2'b00) && (target < limit);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_ifid_register.sv
// rtl/instruction_fetch_unit_ifid_register.sv - IF/ID pipeline register with load, hold and clear
// Ports:
//   clk, resetn          clock and synchronous active-low reset
//   load                 capture instruction/pc_plus4 and mark valid
//   clear                invalidate: valid=0, instruction=NOP (wins over load)
//   instruction          fetched word
//   pc_plus4             fetch PC + 4
//   held_instruction     registered instruction
//   held_pc_plus4        registered PC + 4
//   held_valid           register holds a real instruction
module instruction_fetch_unit_ifid_register
    import instruction_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] instruction,
    input  logic [31:0] pc_plus4,
    output logic [31:0] held_instruction,
    output logic [31:0] held_pc_plus4,
    output logic        held_valid
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            held_instruction <= NOP_WORD;
            held_pc_plus4    <= 32'h0;
            held_valid       <= 1'b0;
        end else if (clear) begin
            // PC+4 is left as is; consumers ignore it while valid is low.
            held_instruction <= NOP_WORD;
            held_valid       <= 1'b0;
        end else if (load) begin
            held_instruction <= instruction;
            held_pc_plus4    <= pc_plus4;
            held_valid       <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC, redirect handling and fetch FSM feeding the IF/ID register
// Ports:
//   Clk, Rst                      clock and synchronous active-low reset
//   Instruction / Address         combinational instruction memory read (Address = PC)
//   Stall, Flush                  pipeline hold / invalidate IF/ID
//   Jump/JumpTarget               highest-priority redirect
//   BranchTaken/BranchTarget      second-priority redirect
//   IFID_Instruction/PCPlus4/Valid IF/ID register contents
//   Halted, Fault, FetchCount     status: HALT state, sticky bad-redirect flag, valid loads
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 128
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] Instruction,
    output logic [31:0] Address,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PCPlus4,
    output logic        IFID_Valid,
    output logic        Halted,
    output logic        Fault,
    output logic [31:0] FetchCount
);

    localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS) * WORD_BYTES;

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next, pc_plus4, target;
    logic         fault_next, redirect, ifid_load, ifid_clear;

    assign pc_plus4 = pc + WORD_BYTES;
    assign redirect = Jump | BranchTaken;
    assign target   = Jump ? JumpTarget : BranchTarget;
    assign Address  = pc;
    assign Halted   = (state == HALT);

    always_ff @(posedge Clk) begin
        if (!Rst) state <= INIT;
        else      state <= state_next;
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            pc         <= RESET_PC;
            Fault      <= 1'b0;
            FetchCount <= 32'h0;
        end else begin
            pc    <= pc_next;
            Fault <= fault_next;
            if (ifid_load && !ifid_clear) FetchCount <= FetchCount + 32'd1;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        fault_next = Fault;
        ifid_load  = 1'b0;
        ifid_clear = 1'b0;
        case (state)
            INIT: begin
                ifid_clear = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                if (redirect) begin
                    // The word fetched from the old PC is dropped either way.
                    ifid_clear = 1'b1;
                    if (target_ok(target, MEM_BYTES)) begin
                        pc_next = target;
                    end else begin
                        fault_next = 1'b1;
                        state_next = HALT;
                    end
                end else if (Stall) begin
                    ifid_clear = Flush;
                end else begin
                    ifid_clear = Flush;
                    ifid_load  = 1'b1;
                    // The last in-range word is still captured; PC parks on it.
                    if (pc_plus4 >= MEM_BYTES) state_next = HALT;
                    else                       pc_next    = pc_plus4;
                end
            end
            HALT: begin
                ifid_clear = 1'b1;
                if (redirect) begin
                    if (target_ok(target, MEM_BYTES)) begin
                        pc_next    = target;
                        state_next = RUN;
                    end else begin
                        fault_next = 1'b1;
                    end
                end
            end
            default: state_next = INIT;
        endcase
    end

    instruction_fetch_unit_ifid_register u_ifid (
        .clk              (Clk),
        .resetn           (Rst),
        .load             (ifid_load),
        .clear            (ifid_clear),
        .instruction      (Instruction),
        .pc_plus4         (pc_plus4),
        .held_instruction (IFID_Instruction),
        .held_pc_plus4    (IFID_PCPlus4),
        .held_valid       (IFID_Valid)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - scoreboard bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_a = 1'b0, rst_b = 1'b0;
    logic        stall = 1'b0, flush = 1'b0, jump = 1'b0, branch = 1'b0;
    logic [31:0] jump_target = 32'h0, branch_target = 32'h0;

    logic [31:0] addr_a, ins_a, pc4_a, cnt_a;
    logic        v_a, h_a, f_a;
    logic [31:0] addr_b, ins_b, pc4_b, cnt_b;
    logic        v_b, h_b, f_b;

    always #5 clk = ~clk;

    instruction_fetch_unit dut_a (
        .Clk(clk), .Rst(rst_a), .Instruction(addr_a), .Address(addr_a),
        .Stall(stall), .Flush(flush), .Jump(jump), .JumpTarget(jump_target),
        .BranchTaken(branch), .BranchTarget(branch_target),
        .IFID_Instruction(ins_a), .IFID_PCPlus4(pc4_a), .IFID_Valid(v_a),
        .Halted(h_a), .Fault(f_a), .FetchCount(cnt_a)
    );

    instruction_fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(8)) dut_b (
        .Clk(clk), .Rst(rst_b), .Instruction(addr_b), .Address(addr_b),
        .Stall(stall), .Flush(flush), .Jump(jump), .JumpTarget(jump_target),
        .BranchTaken(branch), .BranchTarget(branch_target),
        .IFID_Instruction(ins_b), .IFID_PCPlus4(pc4_b), .IFID_Valid(v_b),
        .Halted(h_b), .Fault(f_b), .FetchCount(cnt_b)
    );

    typedef struct {
        string       name;
        bit          which;
        logic [6:0]  mask;   // addr, ins, pc4, valid, halted, fault, count
        logic [31:0] addr, ins, pc4, cnt;
        logic        v, h, f;
    } exp_t;

    localparam logic [6:0] ALL   = 7'h7F;
    localparam logic [6:0] NOPC4 = 7'h7B;

    exp_t q[$];
    int   tests = 0, fails = 0;
    bit   cur = 1'b0;

    task automatic chk(input string name, input string field, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s.%s actual=%h required=%h", name, field, act, req);
        end
    endtask

    task automatic drv(input logic st, input logic fl, input logic jp, input logic [31:0] jt,
                       input logic br, input logic [31:0] bt);
        @(negedge clk);
        stall = st; flush = fl; jump = jp; jump_target = jt; branch = br; branch_target = bt;
    endtask

    task automatic push(input string n, input logic [6:0] m, input logic [31:0] a, input logic [31:0] i,
                        input logic [31:0] p, input logic v, input logic h, input logic f,
                        input logic [31:0] c);
        exp_t e;
        e.name = n; e.which = cur; e.mask = m; e.addr = a; e.ins = i; e.pc4 = p;
        e.v = v; e.h = h; e.f = f; e.cnt = c;
        q.push_back(e);
    endtask

    // Monitor: after every rising edge, compare the DUT state against the oldest expectation.
    initial begin
        exp_t e;
        logic [31:0] a, i, p, c;
        logic v, h, f;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.which) begin a = addr_b; i = ins_b; p = pc4_b; v = v_b; h = h_b; f = f_b; c = cnt_b; end
                else         begin a = addr_a; i = ins_a; p = pc4_a; v = v_a; h = h_a; f = f_a; c = cnt_a; end
                if (e.mask[0]) chk(e.name, "addr",   a, e.addr);
                if (e.mask[1]) chk(e.name, "ins",    i, e.ins);
                if (e.mask[2]) chk(e.name, "pc4",    p, e.pc4);
                if (e.mask[3]) chk(e.name, "valid",  {31'h0, v}, {31'h0, e.v});
                if (e.mask[4]) chk(e.name, "halted", {31'h0, h}, {31'h0, e.h});
                if (e.mask[5]) chk(e.name, "fault",  {31'h0, f}, {31'h0, e.f});
                if (e.mask[6]) chk(e.name, "count",  c, e.cnt);
            end
        end
    end

    initial begin
        // ---------------- MEM_WORDS = 128 ----------------
        cur = 1'b0;
        drv(0, 0, 0, 0, 0, 0);               push("rst",        ALL,   32'h0,   32'h0,   32'h0,   0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0); rst_a = 1'b1; push("init",       ALL,   32'h0,   32'h0,   32'h0,   0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0);               push("f0",         ALL,   32'h4,   32'h0,   32'h4,   1, 0, 0, 1);
        drv(0, 0, 0, 0, 0, 0);               push("f4",         ALL,   32'h8,   32'h4,   32'h8,   1, 0, 0, 2);
        drv(1, 0, 1, 32'h40, 0, 0);          push("jmp_stall",  NOPC4, 32'h40,  32'h0,   32'h0,   0, 0, 0, 2);
        drv(0, 0, 0, 0, 0, 0);               push("jmp_tgt",    ALL,   32'h44,  32'h40,  32'h44,  1, 0, 0, 3);
        drv(0, 0, 0, 0, 0, 0);               push("f44",        ALL,   32'h48,  32'h44,  32'h48,  1, 0, 0, 4);
        drv(0, 0, 0, 0, 1, 32'hC);           push("br",         NOPC4, 32'hC,   32'h0,   32'h0,   0, 0, 0, 4);
        drv(0, 0, 0, 0, 0, 0);               push("br_tgt",     ALL,   32'h10,  32'hC,   32'h10,  1, 0, 0, 5);
        for (int k = 0; k < 3; k++) begin
            drv(1, 0, 0, 0, 0, 0);           push("stall",      ALL,   32'h10,  32'hC,   32'h10,  1, 0, 0, 5);
        end
        drv(0, 0, 0, 0, 0, 0);               push("resume",     ALL,   32'h14,  32'h10,  32'h14,  1, 0, 0, 6);
        drv(1, 1, 0, 0, 0, 0);               push("flush_stall",NOPC4, 32'h14,  32'h0,   32'h0,   0, 0, 0, 6);
        drv(0, 1, 0, 0, 0, 0);               push("flush",      NOPC4, 32'h18,  32'h0,   32'h0,   0, 0, 0, 6);
        drv(0, 0, 0, 0, 0, 0);               push("f18",        ALL,   32'h1C,  32'h18,  32'h1C,  1, 0, 0, 7);
        drv(0, 0, 1, 32'h42, 0, 0);          push("bad_jmp",    NOPC4, 32'h1C,  32'h0,   32'h0,   0, 1, 1, 7);
        drv(0, 0, 0, 0, 0, 0);               push("halt_idle",  NOPC4, 32'h1C,  32'h0,   32'h0,   0, 1, 1, 7);
        drv(0, 0, 1, 32'h200, 0, 0);         push("oor_jmp",    NOPC4, 32'h1C,  32'h0,   32'h0,   0, 1, 1, 7);
        drv(0, 0, 0, 0, 1, 32'h1FC);         push("br_last",    NOPC4, 32'h1FC, 32'h0,   32'h0,   0, 0, 1, 7);
        drv(0, 0, 0, 0, 0, 0);               push("last_word",  ALL,   32'h1FC, 32'h1FC, 32'h200, 1, 1, 1, 8);
        drv(0, 0, 0, 0, 0, 0);               push("end_halt",   NOPC4, 32'h1FC, 32'h0,   32'h0,   0, 1, 1, 8);
        drv(0, 0, 0, 0, 0, 0); rst_a = 1'b0; push("rst_clr",    ALL,   32'h0,   32'h0,   32'h0,   0, 0, 0, 0);

        // ---------------- MEM_WORDS = 8 ----------------
        cur = 1'b1;
        drv(0, 0, 0, 0, 0, 0);               push("b_rst",      ALL,   32'h0,   32'h0,   32'h0,   0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0); rst_b = 1'b1; push("b_init",     ALL,   32'h0,   32'h0,   32'h0,   0, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            drv(0, 0, 0, 0, 0, 0);
            push("b_seq", ALL, (k < 7) ? 32'(k * 4 + 4) : 32'h1C, 32'(k * 4), 32'(k * 4 + 4),
                 1, (k == 7), 0, 32'(k + 1));
        end
        drv(0, 0, 0, 0, 0, 0);               push("b_halt",     NOPC4, 32'h1C,  32'h0,   32'h0,   0, 1, 0, 8);
        drv(1, 1, 0, 0, 0, 0);               push("b_halt_sf",  NOPC4, 32'h1C,  32'h0,   32'h0,   0, 1, 0, 8);
        drv(0, 0, 0, 0, 1, 32'h4);           push("b_restart",  NOPC4, 32'h4,   32'h0,   32'h0,   0, 0, 0, 8);
        drv(0, 0, 0, 0, 0, 0);               push("b_f4",       ALL,   32'h8,   32'h4,   32'h8,   1, 0, 0, 9);
        drv(0, 0, 1, 32'h20, 0, 0);          push("b_oor",      NOPC4, 32'h8,   32'h0,   32'h0,   0, 1, 1, 9);
        drv(0, 0, 0, 0, 0, 0);

        for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
